multicycle_controller: RTL and testbench

Parametrised successor to the current processor controller. A multicycle fetch/decode/execute sequencer that drives the existing register-file/ALU/data-memory datapath. It adds:
- a valid-qualified instruction-memory handshake (variable wait states),
- a HALT state with external resume,
- a real next-state output,
- a retired-instruction counter.

It sits between instruction memory and the datapath inside the processor top level.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_decode.sv | 98 +++++++++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle controller:
//   - state_t     : 8-bit FSM state encoding (these values are visible on the
//                   State_Out / Next_State ports)
//   - OP_*        : opcode values held in the top four instruction bits
//   - get_field   : pulls a right-justified bit field out of an instruction word
//   - get_opcode  : the opcode field of a WIDTH-bit instruction
//   - exec_state  : the state that DECODE moves to for a given opcode
// Instruction words are zero-extended to MAX_W bits before they are passed to
// the helpers, so one set of functions serves every legal WIDTH.
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [7:0] {
    ST_INIT   = 8'd0,
    ST_FETCH  = 8'd1,
    ST_DECODE = 8'd2,
    ST_LOAD_A = 8'd3,
    ST_LOAD_B = 8'd4,
    ST_STORE  = 8'd5,
    ST_ALU    = 8'd6,
    ST_HALT   = 8'd7,
    ST_NOOP   = 8'd8
  } state_t;

  localparam logic [3:0] OP_NOOP     = 4'd0;
  localparam logic [3:0] OP_STORE    = 4'd1;
  localparam logic [3:0] OP_LOAD     = 4'd2;
  localparam logic [3:0] OP_ALU_BASE = 4'd3;
  localparam logic [3:0] OP_HALT     = 4'd15;

  // Widest instruction word the helpers can handle.
  localparam int MAX_W = 64;

  // Returns ir[msb -: len], right-justified and zero-filled above.
  function automatic logic [MAX_W-1:0] get_field(input logic [MAX_W-1:0] ir,
                                                 input int msb, input int len);
    logic [MAX_W-1:0] mask;
    mask = ~({MAX_W{1'b1}} << len);
    return (ir >> (msb - len + 1)) & mask;
  endfunction

  function automatic logic [3:0] get_opcode(input logic [MAX_W-1:0] ir, input int width);
    return 4'(get_field(ir, width - 1, 4));
  endfunction

  function automatic state_t exec_state(input logic [3:0] op);
    case (op)
      OP_NOOP:  return ST_NOOP;
      OP_STORE: return ST_STORE;
      OP_LOAD:  return ST_LOAD_A;
      OP_HALT:  return ST_HALT;
      default:  return ST_ALU;   // opcodes 3..14
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Moore control decode: current state + instruction register -> datapath and
// instruction-memory control. Every output is zero unless the current state
// drives it, so asserting reset (which forces the state to INIT) drops all
// strobes without waiting for a clock edge.
// Ports:
//   i_state                     current FSM state
//   i_ir                        instruction register
//   o_i_rd                      instruction fetch request (FETCH)
//   o_d_addr, o_d_wr            data-memory address / write strobe
//   o_rf_s                      register write-data select (1 = memory)
//   o_rf_w_en                   register write enable
//   o_rf_w_addr/a_addr/b_addr   register-file addresses
//   o_alu_sel                   ALU operation (opcode - 3)
// -----------------------------------------------------------------------------
module mc_decode
  import mc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  state_t              i_state,
  input  logic [WIDTH-1:0]    i_ir,
  output logic                o_i_rd,
  output logic [D_ADDR_W-1:0] o_d_addr,
  output logic                o_d_wr,
  output logic                o_rf_s,
  output logic                o_rf_w_en,
  output logic [R_ADDR_W-1:0] o_rf_w_addr,
  output logic [R_ADDR_W-1:0] o_rf_a_addr,
  output logic [R_ADDR_W-1:0] o_rf_b_addr,
  output logic [3:0]          o_alu_sel
);

  logic [MAX_W-1:0]    w_ir_ext;
  logic [3:0]          w_opcode;
  logic [R_ADDR_W-1:0] w_ra;
  logic [R_ADDR_W-1:0] w_rb;
  logic [R_ADDR_W-1:0] w_rw;
  logic [D_ADDR_W-1:0] w_mem_addr;

  assign w_ir_ext   = MAX_W'(i_ir);
  assign w_opcode   = get_opcode(w_ir_ext, WIDTH);
  // ra sits just below the opcode; rb and rw are the next two fields down.
  assign w_ra       = R_ADDR_W'(get_field(w_ir_ext, WIDTH - 5, R_ADDR_W));
  assign w_rb       = R_ADDR_W'(get_field(w_ir_ext, WIDTH - 5 - R_ADDR_W, R_ADDR_W));
  assign w_rw       = R_ADDR_W'(get_field(w_ir_ext, WIDTH - 5 - 2 * R_ADDR_W, R_ADDR_W));
  assign w_mem_addr = D_ADDR_W'(get_field(w_ir_ext, D_ADDR_W - 1, D_ADDR_W));

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    o_i_rd      = 1'b0;
    o_d_addr    = '0;
    o_d_wr      = 1'b0;
    o_rf_s      = 1'b0;
    o_rf_w_en   = 1'b0;
    o_rf_w_addr = '0;
    o_rf_a_addr = '0;
    o_rf_b_addr = '0;
    o_alu_sel   = '0;

    case (i_state)
      ST_FETCH: begin
        o_i_rd = 1'b1;
      end
      ST_LOAD_A: begin
        o_d_addr    = w_mem_addr;
        o_rf_s      = 1'b1;
        o_rf_w_addr = w_ra;
      end
      ST_LOAD_B: begin
        // Memory read data is captured into ra in this second cycle.
        o_d_addr    = w_mem_addr;
        o_rf_s      = 1'b1;
        o_rf_w_en   = 1'b1;
        o_rf_w_addr = w_ra;
      end
      ST_STORE: begin
        o_d_addr    = w_mem_addr;
        o_rf_a_addr = w_ra;
        o_d_wr      = 1'b1;
      end
      ST_ALU: begin
        o_rf_a_addr = w_ra;
        o_rf_b_addr = w_rb;
        o_rf_w_addr = w_rw;
        o_alu_sel   = w_opcode - OP_ALU_BASE;
        o_rf_s      = 1'b0;
        o_rf_w_en   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Multicycle fetch/decode/execute sequencer for the register-file/ALU/data
// memory datapath. It holds the FSM, PC, IR and retired-instruction counter;
// control decode lives in mc_decode.
// Ports:
//   i_clk, i_rst            clock / asynchronous active-high reset
//   i_resume                leaves HALT when high at a clock edge
//   o_i_rd, o_i_addr        instruction fetch request / address (= PC)
//   i_i_valid, i_i_data     instruction data valid / instruction word
//   o_d_addr, o_d_wr        data-memory address / write strobe
//   o_rf_s, o_rf_w_en       register write-data select / write enable
//   o_rf_w_addr, o_rf_a_addr, o_rf_b_addr   register addresses
//   o_alu_sel               ALU operation
//   o_ir, o_pc              instruction register / program counter
//   o_state, o_next_state   current and next FSM encoding
//   o_retired               retired-instruction count (wraps)
//   o_halted                high in HALT
// -----------------------------------------------------------------------------
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4,
  parameter int I_ADDR_W = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_resume,
  output logic                o_i_rd,
  output logic [I_ADDR_W-1:0] o_i_addr,
  input  logic                i_i_valid,
  input  logic [WIDTH-1:0]    i_i_data,
  output logic [D_ADDR_W-1:0] o_d_addr,
  output logic                o_d_wr,
  output logic                o_rf_s,
  output logic                o_rf_w_en,
  output logic [R_ADDR_W-1:0] o_rf_w_addr,
  output logic [R_ADDR_W-1:0] o_rf_a_addr,
  output logic [R_ADDR_W-1:0] o_rf_b_addr,
  output logic [3:0]          o_alu_sel,
  output logic [WIDTH-1:0]    o_ir,
  output logic [I_ADDR_W-1:0] o_pc,
  output logic [7:0]          o_state,
  output logic [7:0]          o_next_state,
  output logic [15:0]         o_retired,
  output logic                o_halted
);

  // Parameter sanity, checked at elaboration.
  if (WIDTH != 4 + R_ADDR_W + D_ADDR_W) begin : g_bad_width
    $error("multicycle_controller: WIDTH must equal 4 + R_ADDR_W + D_ADDR_W");
  end
  if (D_ADDR_W < 2 * R_ADDR_W) begin : g_bad_d_addr_w
    $error("multicycle_controller: D_ADDR_W must be >= 2 * R_ADDR_W");
  end
  if (WIDTH > MAX_W) begin : g_too_wide
    $error("multicycle_controller: WIDTH exceeds mc_pkg::MAX_W");
  end

  state_t              r_state;
  state_t              w_next_state;
  logic [I_ADDR_W-1:0] r_pc;
  logic [WIDTH-1:0]    r_ir;
  logic [15:0]         r_retired;
  logic [3:0]          w_opcode;
  logic                w_fetch_done;
  logic                w_retire;

  assign w_opcode     = get_opcode(MAX_W'(r_ir), WIDTH);
  assign w_fetch_done = (r_state == ST_FETCH) && i_i_valid;

  // An instruction retires as it leaves its last execute state; HALT counts
  // on entry so a long halt does not delay the count.
  assign w_retire = (r_state inside {ST_LOAD_B, ST_STORE, ST_ALU, ST_NOOP}) ||
                    ((r_state == ST_DECODE) && (w_next_state == ST_HALT));

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: non-blocking assignments for all clocked state, so every register
      // samples pre-edge values regardless of block ordering.
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:   w_next_state = ST_FETCH;
      ST_FETCH:  if (i_i_valid) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = exec_state(w_opcode);
      ST_LOAD_A: w_next_state = ST_LOAD_B;
      ST_LOAD_B,
      ST_STORE,
      ST_ALU,
      ST_NOOP:   w_next_state = ST_FETCH;
      ST_HALT:   if (i_resume) w_next_state = ST_FETCH;
      default:   w_next_state = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC, IR and retired counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: only these few control registers take a reset; they define the
      // restart point, and there is no storage array here to clear.
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      if (w_fetch_done) begin
        r_ir <= i_i_data;
        r_pc <= r_pc + 1'b1;   // wraps naturally at 2^I_ADDR_W
      end
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: Moore output decode
  // ---------------------------------------------------------------------------
  mc_decode #(
    .WIDTH    (WIDTH),
    .D_ADDR_W (D_ADDR_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_decode (
    .i_state     (r_state),
    .i_ir        (r_ir),
    .o_i_rd      (o_i_rd),
    .o_d_addr    (o_d_addr),
    .o_d_wr      (o_d_wr),
    .o_rf_s      (o_rf_s),
    .o_rf_w_en   (o_rf_w_en),
    .o_rf_w_addr (o_rf_w_addr),
    .o_rf_a_addr (o_rf_a_addr),
    .o_rf_b_addr (o_rf_b_addr),
    .o_alu_sel   (o_alu_sel)
  );

  assign o_i_addr     = r_pc;
  assign o_pc         = r_pc;
  assign o_ir         = r_ir;
  assign o_state      = r_state;
  assign o_next_state = w_next_state;
  assign o_retired    = r_retired;
  assign o_halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed steps followed by a random instruction stream. The reference model
// works per instruction: it knows which states an opcode passes through, what
// each state must present, and how PC / IR / retired count change once the
// instruction is done. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_resume;
  logic        o_i_rd;
  logic [6:0]  o_i_addr;
  logic        i_i_valid;
  logic [15:0] i_i_data;
  logic [7:0]  o_d_addr;
  logic        o_d_wr;
  logic        o_rf_s;
  logic        o_rf_w_en;
  logic [3:0]  o_rf_w_addr;
  logic [3:0]  o_rf_a_addr;
  logic [3:0]  o_rf_b_addr;
  logic [3:0]  o_alu_sel;
  logic [15:0] o_ir;
  logic [6:0]  o_pc;
  logic [7:0]  o_state;
  logic [7:0]  o_next_state;
  logic [15:0] o_retired;
  logic        o_halted;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state.
  int          m_pc  = 0;
  logic [15:0] m_ir  = '0;
  int          m_ret = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_resume     (i_resume),
    .o_i_rd       (o_i_rd),
    .o_i_addr     (o_i_addr),
    .i_i_valid    (i_i_valid),
    .i_i_data     (i_i_data),
    .o_d_addr     (o_d_addr),
    .o_d_wr       (o_d_wr),
    .o_rf_s       (o_rf_s),
    .o_rf_w_en    (o_rf_w_en),
    .o_rf_w_addr  (o_rf_w_addr),
    .o_rf_a_addr  (o_rf_a_addr),
    .o_rf_b_addr  (o_rf_b_addr),
    .o_alu_sel    (o_alu_sel),
    .o_ir         (o_ir),
    .o_pc         (o_pc),
    .o_state      (o_state),
    .o_next_state (o_next_state),
    .o_retired    (o_retired),
    .o_halted     (o_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // State number plus the four strobes; Halted must track the HALT state.
  task automatic chk_ctrl(input string tag, input int st, input logic ird,
                          input logic dwr, input logic rfw, input logic rfs);
    chk({tag, "_state"},   32'(o_state),   st);
    chk({tag, "_i_rd"},    32'(o_i_rd),    32'(ird));
    chk({tag, "_d_wr"},    32'(o_d_wr),    32'(dwr));
    chk({tag, "_rf_w_en"}, 32'(o_rf_w_en), 32'(rfw));
    chk({tag, "_rf_s"},    32'(o_rf_s),    32'(rfs));
    chk({tag, "_halted"},  32'(o_halted),  (st == 7) ? 32'd1 : 32'd0);
  endtask

  // Random values on inputs the current state must ignore.
  task automatic noise();
    i_i_valid = 1'($urandom_range(0, 1));
    i_i_data  = 16'($urandom);
    i_resume  = 1'($urandom_range(0, 1));
  endtask

  // One complete instruction: `waits` FETCH cycles without I_valid, the valid
  // FETCH cycle, DECODE, then the execute state(s). For HALT, `halt_cycles`
  // HALT cycles see Resume low before one cycle with Resume high.
  task automatic run_instr(input logic [15:0] instr, input int waits, input int halt_cycles);
    int op;
    int exec_st;
    op = int'(instr[15:12]);
    if (op == 0)       exec_st = 8;
    else if (op == 1)  exec_st = 5;
    else if (op == 2)  exec_st = 3;
    else if (op == 15) exec_st = 7;
    else               exec_st = 6;

    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      chk_ctrl("fetch", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fetch_pc",     32'(o_pc),      m_pc);
      chk("fetch_i_addr", 32'(o_i_addr),  m_pc);
      chk("fetch_ir",     32'(o_ir),      32'(m_ir));
      chk("fetch_ret",    32'(o_retired), m_ret);
      i_i_valid = (w == waits);
      i_i_data  = (w == waits) ? instr : 16'($urandom);
      i_resume  = 1'($urandom_range(0, 1));
      #1 chk("fetch_next", 32'(o_next_state), (w == waits) ? 32'd2 : 32'd1);
    end
    m_ir = instr;
    m_pc = (m_pc + 1) % 128;

    @(negedge clk);
    chk_ctrl("decode", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("decode_ir",  32'(o_ir), 32'(m_ir));
    chk("decode_pc",  32'(o_pc), m_pc);
    noise();
    #1 chk("decode_next", 32'(o_next_state), exec_st);

    if (op == 0) begin
      @(negedge clk);
      chk_ctrl("noop", 8, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("noop_ret", 32'(o_retired), m_ret);
      noise();
      #1 chk("noop_next", 32'(o_next_state), 1);
      m_ret++;
    end else if (op == 1) begin
      @(negedge clk);
      chk_ctrl("store", 5, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("store_d_addr", 32'(o_d_addr),    32'(instr[7:0]));
      chk("store_a_addr", 32'(o_rf_a_addr), 32'(instr[11:8]));
      chk("store_ir",     32'(o_ir),        32'(m_ir));
      noise();
      #1 chk("store_next", 32'(o_next_state), 1);
      m_ret++;
    end else if (op == 2) begin
      @(negedge clk);
      chk_ctrl("load_a", 3, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("load_a_d_addr", 32'(o_d_addr), 32'(instr[7:0]));
      noise();
      #1 chk("load_a_next", 32'(o_next_state), 4);
      @(negedge clk);
      chk_ctrl("load_b", 4, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("load_b_d_addr", 32'(o_d_addr),    32'(instr[7:0]));
      chk("load_b_w_addr", 32'(o_rf_w_addr), 32'(instr[11:8]));
      chk("load_b_ret",    32'(o_retired),   m_ret);
      noise();
      #1 chk("load_b_next", 32'(o_next_state), 1);
      m_ret++;
    end else if (op == 15) begin
      m_ret++;   // counted on entry to HALT
      for (int i = 0; i <= halt_cycles; i++) begin
        @(negedge clk);
        chk_ctrl("halt", 7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_ret", 32'(o_retired), m_ret);
        chk("halt_pc",  32'(o_pc),      m_pc);
        i_i_valid = 1'($urandom_range(0, 1));
        i_i_data  = 16'($urandom);
        i_resume  = (i == halt_cycles);
        #1 chk("halt_next", 32'(o_next_state), (i == halt_cycles) ? 32'd1 : 32'd7);
      end
    end else begin
      @(negedge clk);
      chk_ctrl("alu", 6, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("alu_sel",    32'(o_alu_sel),   op - 3);
      chk("alu_a_addr", 32'(o_rf_a_addr), 32'(instr[11:8]));
      chk("alu_b_addr", 32'(o_rf_b_addr), 32'(instr[7:4]));
      chk("alu_w_addr", 32'(o_rf_w_addr), 32'(instr[3:0]));
      noise();
      #1 chk("alu_next", 32'(o_next_state), 1);
      m_ret++;
    end
  endtask

  initial begin
    logic [15:0] instr;
    int          waits;

    rst       = 1'b1;
    i_resume  = 1'b0;
    i_i_valid = 1'b0;
    i_i_data  = '0;

    // Held in reset.
    #12;
    chk_ctrl("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_next",    32'(o_next_state), 1);
    chk("reset_pc",      32'(o_pc),         0);
    chk("reset_ir",      32'(o_ir),         0);
    chk("reset_retired", 32'(o_retired),    0);

    @(negedge clk);
    rst = 1'b0;
    #1 chk("init_state", 32'(o_state), 0);

    // NOOP: 0,1,2,8 then back to FETCH with PC=1, Retired=1.
    run_instr(16'h0000, 0, 0);
    // LOAD ra=10 addr 0x05.
    run_instr(16'h2A05, 0, 0);
    // ALU op 2, A=1 B=2 W=3.
    run_instr(16'h5123, 0, 0);
    // Three wait states before I_valid.
    run_instr(16'h1C7E, 3, 0);
    // HALT held 5 cycles, then a one-cycle Resume.
    run_instr(16'hF000, 0, 5);

    // Random stream, long enough for the PC to wrap past 0x7F.
    for (int n = 0; n < 150; n++) begin
      instr = 16'($urandom);
      waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(instr, waits, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a STORE.
    @(negedge clk);
    chk("pre_store_state", 32'(o_state), 1);
    i_i_valid = 1'b1;
    i_i_data  = 16'h1A33;
    @(negedge clk);
    i_i_valid = 1'b0;
    @(negedge clk);
    chk("mid_store_d_wr", 32'(o_d_wr), 1);
    #2 rst = 1'b1;
    #1;
    chk_ctrl("abort", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_pc",      32'(o_pc),         0);
    chk("abort_ir",      32'(o_ir),         0);
    chk("abort_retired", 32'(o_retired),    0);
    chk("abort_next",    32'(o_next_state), 1);
    m_pc  = 0;
    m_ir  = '0;
    m_ret = 0;
    @(negedge clk);
    rst = 1'b0;
    run_instr(16'h0000, 1, 0);
    run_instr(16'h3FFF, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
